// File: rtl/command_decoder.sv
// ---------------------------------------------------------------------------
// command_decoder
//
// Receive side of the host debug link. Parses ASCII command lines arriving on
// an AXI-Stream slave and issues one bus access per complete command.
//
//   read : "r" AAAAAAAA LF
//   write: "w" AAAAAAAA DDDDDDDD LF
//
// Hex digits are lowercase, MSB nibble first, exactly 8 per field. CR is
// ignored wherever bytes are accepted. Malformed lines raise a one-cycle Err
// and the rest of the line is discarded up to LF.
//
// Optional feature macro: CMD_UPPERCASE_EN
//   defined   -> 'A'-'F' accepted as hex digits, 'R'/'W' accepted as opcodes
//   undefined -> uppercase letters are malformed
//
// Parameters:
//   ACK_TIMEOUT   cycles to wait for Ack while Cs is high (0 = wait forever)
//
// Ports:
//   Clk            in   clock
//   Rst            in   synchronous active-high reset
//   S_axis_tvalid  in   command byte valid
//   S_axis_tdata   in   command byte (ASCII)
//   S_axis_tready  out  decoder can accept a byte (low only during BUS)
//   Cs             out  bus chip select, held until Ack or timeout
//   We             out  1 = write, 0 = read; valid while Cs is high
//   Addr           out  bus address
//   Wdata          out  bus write data
//   Ack            in   bus access complete, sampled while Cs is high
//   Err            out  one-cycle pulse on malformed command or Ack timeout
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module command_decoder #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    S_axis_tvalid,
    input  logic [7:0]              S_axis_tdata,
    output logic                    S_axis_tready,
    output logic                    Cs,
    output logic                    We,
    output logic [`WORD_SIZE-1:0]   Addr,
    output logic [`WORD_SIZE-1:0]   Wdata,
    input  logic                    Ack,
    output logic                    Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_EOL,
        S_BUS,
        S_DISCARD
    } state_t;

    // Last count value before the access is abandoned; unused when the
    // timeout is disabled.
    localparam logic [31:0] TMO_LAST = (ACK_TIMEOUT == 0) ? 32'd0 : 32'(ACK_TIMEOUT - 1);

    state_t                  r_state;
    logic                    r_is_wr;
    logic [2:0]              r_cnt;
    logic [31:0]             r_tmo;
    logic                    r_cs;
    logic                    r_we;
    logic [`WORD_SIZE-1:0]   r_addr;
    logic [`WORD_SIZE-1:0]   r_wdata;
    logic                    r_err;

    logic                    w_take;
    logic                    w_is_hex;
    logic [3:0]              w_nib;
    logic                    w_is_cr;
    logic                    w_is_lf;
    logic                    w_is_r;
    logic                    w_is_w;

    assign S_axis_tready = (r_state != S_BUS);
    assign w_take        = S_axis_tvalid && (r_state != S_BUS);

    assign Cs    = r_cs;
    assign We    = r_we;
    assign Addr  = r_addr;
    assign Wdata = r_wdata;
    assign Err   = r_err;

    // Byte classification
    always_comb begin
        w_is_hex = 1'b0;
        w_nib    = 4'h0;
        w_is_cr  = (S_axis_tdata == 8'h0d);
        w_is_lf  = (S_axis_tdata == 8'h0a);
        w_is_r   = (S_axis_tdata == 8'h72);
        w_is_w   = (S_axis_tdata == 8'h77);
        if (S_axis_tdata >= 8'h30 && S_axis_tdata <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(S_axis_tdata - 8'h30);
        end else if (S_axis_tdata >= 8'h61 && S_axis_tdata <= 8'h66) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(S_axis_tdata - 8'h57);
        end
`ifdef CMD_UPPERCASE_EN
        else if (S_axis_tdata >= 8'h41 && S_axis_tdata <= 8'h46) begin
            w_is_hex = 1'b1;
            w_nib    = 4'(S_axis_tdata - 8'h37);
        end
        if (S_axis_tdata == 8'h52) w_is_r = 1'b1;
        if (S_axis_tdata == 8'h57) w_is_w = 1'b1;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_is_wr <= 1'b0;
            r_cnt   <= 3'd0;
            r_tmo   <= 32'd0;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take && !w_is_cr && !w_is_lf) begin
                        if (w_is_r || w_is_w) begin
                            // Fresh fields per command so a partial line never leaks
                            r_is_wr <= w_is_w;
                            r_addr  <= '0;
                            r_wdata <= '0;
                            r_cnt   <= 3'd0;
                            r_state <= S_ADDR;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_DISCARD;
                        end
                    end
                end

                S_ADDR, S_DATA: begin
                    if (w_take && !w_is_cr) begin
                        if (w_is_hex) begin
                            if (r_state == S_ADDR)
                                r_addr  <= {r_addr[`WORD_SIZE-5:0], w_nib};
                            else
                                r_wdata <= {r_wdata[`WORD_SIZE-5:0], w_nib};
                            if (r_cnt == 3'd7) begin
                                r_cnt   <= 3'd0;
                                r_state <= (r_state == S_ADDR && r_is_wr) ? S_DATA : S_EOL;
                            end else begin
                                r_cnt <= r_cnt + 3'd1;
                            end
                        end else if (w_is_lf) begin
                            // Short field: line already ended, no discard needed
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_DISCARD;
                        end
                    end
                end

                S_EOL: begin
                    if (w_take && !w_is_cr) begin
                        if (w_is_lf) begin
                            r_cs    <= 1'b1;
                            r_we    <= r_is_wr;
                            r_tmo   <= 32'd0;
                            r_state <= S_BUS;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_DISCARD;
                        end
                    end
                end

                S_BUS: begin
                    // Ack wins over a timeout expiring in the same cycle
                    if (Ack) begin
                        r_cs    <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (ACK_TIMEOUT != 0) begin
                        if (r_tmo == TMO_LAST) begin
                            r_cs    <= 1'b0;
                            r_we    <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_tmo <= r_tmo + 32'd1;
                        end
                    end
                end

                S_DISCARD: begin
                    if (w_take && w_is_lf)
                        r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_decoder.sv
// ---------------------------------------------------------------------------
// tb_command_decoder
//
// Table-driven bench for command_decoder. Each record holds a command line,
// the Ack behaviour of the bus model and the expected bus access / Err
// activity. Reset corner cases are exercised by hand-written sequences.
// In command strings '^' stands for CR.
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_command_decoder;

    localparam int TMO = 16;

    logic                   Clk;
    logic                   Rst;
    logic                   S_axis_tvalid;
    logic [7:0]             S_axis_tdata;
    logic                   S_axis_tready;
    logic                   Cs;
    logic                   We;
    logic [`WORD_SIZE-1:0]  Addr;
    logic [`WORD_SIZE-1:0]  Wdata;
    logic                   Ack;
    logic                   Err;

    command_decoder #(.ACK_TIMEOUT(TMO)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .S_axis_tvalid (S_axis_tvalid),
        .S_axis_tdata  (S_axis_tdata),
        .S_axis_tready (S_axis_tready),
        .Cs            (Cs),
        .We            (We),
        .Addr          (Addr),
        .Wdata         (Wdata),
        .Ack           (Ack),
        .Err           (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Record: cmd, ack delay (-1 = never), Err cycles, Cs rises, Cs high cycles, We, Addr, Wdata
    typedef struct {
        string       cmd;
        int          ack;
        int          exp_err;
        int          exp_cs;
        int          exp_hi;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Bus model: Ack rises once Cs has been high for more than ack_delay cycles
    int ack_delay = 0;
    int cs_age    = 0;
    initial begin
        Ack = 1'b0;
        forever begin
            @(negedge Clk);
            if (Cs) cs_age = cs_age + 1;
            else    cs_age = 0;
            Ack = (ack_delay >= 0) && Cs && (cs_age > ack_delay);
        end
    end

    // Monitor: cumulative activity counters
    int          err_cyc  = 0;
    int          cs_cyc   = 0;
    int          cs_rise  = 0;
    int          bus_rdy  = 0;
    int          unstable = 0;
    logic        cs_prev  = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic        cap_we   = 1'b0;

    always @(negedge Clk) begin
        if (Err) err_cyc <= err_cyc + 1;
        if (Cs)  cs_cyc  <= cs_cyc + 1;
        if (Cs && !cs_prev) begin
            cs_rise   <= cs_rise + 1;
            cap_addr  <= Addr;
            cap_wdata <= Wdata;
            cap_we    <= We;
        end
        if (Cs && cs_prev && (Addr != cap_addr || Wdata != cap_wdata || We != cap_we))
            unstable <= unstable + 1;
        if (Cs && S_axis_tready) bus_rdy <= bus_rdy + 1;
        cs_prev <= Cs;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives a line byte by byte; called and returns on a negative edge
    task automatic send(input string s);
        logic [7:0] b;
        int guard;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            if (b == 8'h5e) b = 8'h0d;
            guard = 0;
            while (!S_axis_tready && guard < 200) begin
                @(negedge Clk);
                guard++;
            end
            if (guard >= 200) chk("tready_wait", 64'd0, 64'd1);
            S_axis_tvalid = 1'b1;
            S_axis_tdata  = b;
            @(negedge Clk);
        end
        S_axis_tvalid = 1'b0;
        S_axis_tdata  = 8'h00;
    endtask

    task automatic run_vec(input int idx);
        int e0, r0, h0;
        vec_t v;
        v  = vecs[idx];
        e0 = err_cyc;
        r0 = cs_rise;
        h0 = cs_cyc;
        ack_delay = v.ack;
        send(v.cmd);
        repeat (40) @(negedge Clk);
        chk($sformatf("v%0d_err", idx), 64'(err_cyc - e0), 64'(v.exp_err));
        chk($sformatf("v%0d_cs", idx), 64'(cs_rise - r0), 64'(v.exp_cs));
        chk($sformatf("v%0d_idle_tready", idx), 64'(S_axis_tready), 64'd1);
        chk($sformatf("v%0d_idle_cs", idx), 64'(Cs), 64'd0);
        if (v.exp_cs != 0) begin
            chk($sformatf("v%0d_cs_hi", idx), 64'(cs_cyc - h0), 64'(v.exp_hi));
            chk($sformatf("v%0d_we", idx), 64'(cap_we), 64'(v.exp_we));
            chk($sformatf("v%0d_addr", idx), 64'(cap_addr), 64'(v.exp_addr));
            if (v.exp_we) chk($sformatf("v%0d_wdata", idx), 64'(cap_wdata), 64'(v.exp_wdata));
        end
    endtask

    initial begin
        int e0, r0;

        vecs.push_back('{"r00000010\n",            3, 0, 1,  4, 1'b0, 32'h00000010, 32'h0});
        vecs.push_back('{"w0000000cdeadbeef\n",    0, 0, 1,  1, 1'b1, 32'h0000000c, 32'hdeadbeef});
        vecs.push_back('{"r00g00000\n",            0, 1, 0,  0, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{"r00000004\n",            0, 0, 1,  1, 1'b0, 32'h00000004, 32'h0});
        vecs.push_back('{"r1234\n",                0, 1, 0,  0, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{"r000000ff^\n",           0, 0, 1,  1, 1'b0, 32'h000000ff, 32'h0});
        vecs.push_back('{"r00000000\n",           -1, 1, 1, 16, 1'b0, 32'h00000000, 32'h0});
        vecs.push_back('{"\n",                     0, 0, 0,  0, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{"x\n",                    0, 1, 0,  0, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{"w00000001\n",            0, 1, 0,  0, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{"r000000011\n",           0, 1, 0,  0, 1'b0, 32'h0,        32'h0});
        vecs.push_back('{"^^w^1234567887654321^\n", 2, 0, 1, 3, 1'b1, 32'h12345678, 32'h87654321});
`ifdef CMD_UPPERCASE_EN
        vecs.push_back('{"R0000ABCD\n",            0, 0, 1,  1, 1'b0, 32'h0000abcd, 32'h0});
`else
        vecs.push_back('{"R0000ABCD\n",            0, 1, 0,  0, 1'b0, 32'h0,        32'h0});
`endif
        vecs.push_back('{"r0000abcd\n",            1, 0, 1,  2, 1'b0, 32'h0000abcd, 32'h0});

        Rst           = 1'b1;
        S_axis_tvalid = 1'b0;
        S_axis_tdata  = 8'h00;
        repeat (3) @(negedge Clk);

        chk("rst_cs",     64'(Cs),            64'd0);
        chk("rst_we",     64'(We),            64'd0);
        chk("rst_addr",   64'(Addr),          64'd0);
        chk("rst_wdata",  64'(Wdata),         64'd0);
        chk("rst_err",    64'(Err),           64'd0);
        chk("rst_tready", 64'(S_axis_tready), 64'd1);
        Rst = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // Reset while the access is pending on the bus
        ack_delay = -1;
        send("r00000020\n");
        repeat (3) @(negedge Clk);
        chk("bus_cs_before_rst", 64'(Cs), 64'd1);
        e0  = err_cyc;
        Rst = 1'b1;
        @(negedge Clk);
        chk("rstbus_cs",     64'(Cs),            64'd0);
        chk("rstbus_err",    64'(Err),           64'd0);
        chk("rstbus_tready", 64'(S_axis_tready), 64'd1);
        chk("rstbus_addr",   64'(Addr),          64'd0);
        Rst = 1'b0;
        repeat (20) @(negedge Clk);
        chk("rstbus_no_err", 64'(err_cyc - e0), 64'd0);

        // Reset in the middle of a command line, then a clean command
        ack_delay = 0;
        e0 = err_cyc;
        r0 = cs_rise;
        send("w0000");
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        send("r00000008\n");
        repeat (10) @(negedge Clk);
        chk("rstcmd_cs",   64'(cs_rise - r0), 64'd1);
        chk("rstcmd_we",   64'(cap_we),       64'd0);
        chk("rstcmd_addr", 64'(cap_addr),     64'h8);
        chk("rstcmd_err",  64'(err_cyc - e0), 64'd0);

        chk("bus_tready_low", 64'(bus_rdy),  64'd0);
        chk("bus_stable",     64'(unstable), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/command_decoder.md
Name: command_decoder

Overview:
- Receive side of the host debug link.
- Consumes ASCII command bytes from an AXI-Stream slave, parses hex address and data fields, and issues one bus access per command on the Cs/We/Addr/Wdata/Ack interface.
- Read data is returned to the host by response_coder, which monitors the same Cs/We/Ack signals; this block handles parsing and bus issue only.

Parameters:
- ACK_TIMEOUT, 1024: cycles to wait for Ack with Cs high before aborting the access; 0 disables the timeout.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- S_axis_tvalid  in  1  command byte valid
- S_axis_tdata  in  8  command byte (ASCII)
- S_axis_tready  out  1  decoder can accept a byte
- Cs  out  1  bus chip select, held until Ack
- We  out  1  1 = write, 0 = read; valid while Cs is high
- Addr  out  `WORD_SIZE  bus address
- Wdata  out  `WORD_SIZE  bus write data
- Ack  in  1  bus access complete; sampled while Cs is high
- Err  out  1  one-cycle pulse on malformed command or Ack timeout

Behaviour:
- Interface: one clock (Clk); reset is synchronous and active-high (Rst).
- Reset: state=IDLE; Cs=0, We=0, Addr=0, Wdata=0, Err=0; digit and timeout counters cleared. Rst asserted mid-command or mid-access aborts immediately: Cs drops on the next edge and no Err is raised.
- Byte transfer: a byte is consumed only on S_axis_tvalid & S_axis_tready.
- S_axis_tready is state-decoded: 1 in IDLE, ADDR, DATA, EOL and DISCARD; 0 in BUS.
- Command grammar (lowercase hex, MSB nibble first, exactly 8 digits per field):
  - read: "r" AAAAAAAA LF
  - write: "w" AAAAAAAA DDDDDDDD LF
- CR (0x0d) is consumed and ignored in every state that accepts bytes.
- States and transitions:
  - IDLE: 'r' -> ADDR with We_next=0. 'w' -> ADDR with We_next=1. LF -> stay in IDLE, no Err (empty line). Any other byte -> Err pulse, go to DISCARD.
  - ADDR: each hex digit shifts in, Addr <= {Addr[27:0], nibble}; digit count 0..7. After the 8th digit: read -> EOL, write -> DATA. A non-hex byte -> Err, DISCARD. LF before the 8th digit -> Err, IDLE.
  - DATA: same shifting rules applied to Wdata; after the 8th digit -> EOL.
  - EOL: LF -> BUS, with Cs=1 and We set from the opcode. Any other byte -> Err, DISCARD.
  - BUS: Cs, We, Addr and Wdata are held stable. When Ack=1 is sampled: Cs<=0, We<=0, go to IDLE (Cs is high for at least one cycle). If the timeout counter reaches ACK_TIMEOUT first: Cs<=0, Err pulse, IDLE.
  - DISCARD: drop every byte until LF, then IDLE. No further Err pulses while in DISCARD.
- Addr and Wdata are cleared to 0 on every opcode acceptance, so a partial field never leaks into the next command. Both keep their last value after the access completes.
- Err is registered and high for exactly one cycle per error event.
- Latency: Cs rises on the clock edge that consumes the LF byte. The earliest a new opcode can be accepted is the cycle after Cs falls.

Optional Feature:
- CMD_UPPERCASE_EN
- Defined:
  - 'A'-'F' are accepted as hex digits (values 10-15).
  - 'R' and 'W' are accepted as opcodes.
- Undefined:
  - Uppercase letters are malformed and take the Err -> DISCARD path.

Test Plan:
- Read: "r00000010\n", Ack asserted 3 cycles after Cs -> Cs=1, We=0, Addr=0x00000010 held until Ack; then Cs=0, state IDLE, no Err.
- Write: "w0000000cdeadbeef\n", Ack immediate -> exactly one cycle of Cs=1, We=1, Addr=0x0000000c, Wdata=0xdeadbeef; tready=0 in that cycle.
- Malformed digit: "r00g00000\n", then "r00000004\n" -> one Err pulse at 'g', no Cs for the first line; second line gives Cs with Addr=0x00000004.
- Short field and CR: "r1234\n" -> Err, no Cs. Then "r000000ff\r\n" -> Cs with Addr=0x000000ff, no Err.
- Timeout: ACK_TIMEOUT=16, "r00000000\n", Ack never asserted -> Cs high for 16 cycles, then Cs=0 with one Err pulse, decoder back in IDLE.
- Reset and feature macro: Rst asserted while in BUS -> next cycle Cs=0, Err=0, tready=1. With CMD_UPPERCASE_EN defined, "R0000ABCD\n" -> Addr=0x0000abcd; without it -> Err.
